rom_responder: RTL
==================

# rom_responder

Far-end responder for the remote ROM link. Pops a byte-serial 64-bit read address from the command FIFO, issues one word read on a local memory port, and pushes the 64-bit result byte-serially into the response FIFO. It sits on the far clock side of the `ip_fifo` pair, with command FIFO read port in and response FIFO write port out. It is the counterpart of `remote_rom`. Both directions are LSB byte first.

## Interface
Parameters:
- `BYTES`, 8: bytes per address and per data word; address and data width = 8*BYTES.
- `TIMEOUT`, 255: max MEM cycles waiting for `mem_ack`; 0 disables the timeout.

Ports:
- `clk`  in  1  single clock; everything is synchronous to its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `empty`  in  1  command FIFO empty.
- `rd_en`  out  1  command FIFO pop.
- `dout`  in  8  command FIFO data; valid the cycle after `rd_en`.
- `full`  in  1  response FIFO full.
- `wr_en`  out  1  response FIFO push.
- `din`  out  8  response FIFO data; qualified by `wr_en`.
- `mem_req`  out  1  read request; held until ack or timeout.
- `mem_addr`  out  8*BYTES  assembled address; stable while `mem_req`=1.
- `mem_ack`  in  1  single-cycle read completion.
- `mem_rdata`  in  8*BYTES  read data; valid with `mem_ack`.
- `busy`  out  1  a transaction is in progress.
- `err_cnt`  out  8  saturating count of timed-out reads.

## Operation
- States: CMD_RD, CMD_CAP, MEM, RSP. Reset state is CMD_RD.
- CMD_RD
  - `rd_en` = !empty (combinational).
  - If !empty, go to CMD_CAP; otherwise stay.
- CMD_CAP
  - Capture `addr <= {dout, addr[8*BYTES-1:8]}` and `cnt <= cnt+1`.
  - If `cnt` was BYTES-1, clear `cnt` and go to MEM; else go to CMD_RD.
  - Address assembly is non-pipelined: at most one byte per 2 cycles.
- MEM
  - `mem_req`=1 and `mem_addr`=`addr`.
  - On `mem_ack`: `data <= mem_rdata`, clear the timer, go to RSP. The ack may arrive in the first MEM cycle.
  - Else if TIMEOUT!=0 and `timer`==TIMEOUT-1: `data <=` all ones, `err_cnt` += 1 (saturating at 255), go to RSP.
  - Else `timer` += 1.
- RSP
  - `wr_en` = !full (combinational) and `din` = `data[7:0]`.
  - On each push: `data <= {8'h00, data[8*BYTES-1:8]}` and `cnt` += 1.
  - After the BYTES-th push, clear `cnt` and go to CMD_RD.
  - While `full`=1: no push, `data` and `cnt` hold.
- `busy` = (state!=CMD_RD) || (`cnt`!=0).
- Width rules:
  - `cnt` is $clog2(BYTES) bits and compares against BYTES-1 explicitly, so BYTES need not be a power of 2.
  - `timer` is $clog2(TIMEOUT+1) bits.
- Responses are never reordered or dropped; exactly BYTES response bytes are produced per BYTES command bytes.

## Timing
- Reset values:
  - Outputs: `rd_en`=0, `wr_en`=0, `din`=0, `mem_req`=0, `mem_addr`=0, `busy`=0, `err_cnt`=0.
  - Internal: `addr`, `data`, `cnt` and `timer` all 0.
- `rd_en`, `wr_en` and `mem_req` are decoded from state plus FIFO flags. They never assert while `empty`/`full`.
- Minimum transaction latency: 2*BYTES cycles of address + 1 MEM cycle + BYTES response cycles. For BYTES=8 that is 25 cycles from first `rd_en` to last `wr_en` inclusive.
- Every `empty` cycle in CMD_RD and every `full` cycle in RSP adds exactly one cycle.
- Back-to-back transactions: the cycle after the last push, the block is in CMD_RD and may pop again.
- `mem_ack` outside MEM is ignored.
- `empty` and `full` are irrelevant outside CMD_RD and RSP respectively.
- Reset mid-operation: immediate return to CMD_RD with `cnt` cleared. A partially assembled address or partially sent response is discarded; FIFO resync is the link's responsibility.
- `err_cnt` survives everything except `rst`.

## Test plan
- Command bytes 01 23 45 67 89 AB CD EF, `mem_ack` in the first MEM cycle with `mem_rdata`=64'h0123_4567_89AB_CDEF:
  - `mem_addr`=64'hEFCD_AB89_6745_2301.
  - `din` sequence EF CD AB 89 67 45 23 01.
  - 25 cycles total; `busy` drops after the last push.
- `empty` toggling every other cycle during address bytes:
  - The address is identical to the first scenario.
  - `rd_en` is never high while `empty`=1.
  - Latency grows by one cycle per empty cycle seen in CMD_RD.
- `full` held for 5 cycles after the third push:
  - No `wr_en` during the stall.
  - The fourth byte (89) is delivered after `full` drops.
  - Byte order is intact.
- `mem_ack` never asserted, TIMEOUT=255:
  - `mem_req` is high for exactly 255 cycles.
  - Eight FF bytes are pushed.
  - `err_cnt`=1; a second timed-out read gives `err_cnt`=2.
- Two back-to-back transactions with addresses 0x...2301 and 0x...CDEF and distinct rdata:
  - Second `rd_en` occurs the cycle after the last `wr_en`.
  - 16 response bytes arrive in order.
- `rst` pulsed after 3 address bytes:
  - All outputs return to reset values immediately.
  - A fresh 8-byte command then completes normally with correct `mem_addr`.

Source files
------------

// File: rtl/rom_responder.sv
// Far-end responder of the remote ROM link: pops a byte-serial read address from the
// command FIFO, performs one word read on the local memory port, and streams the word back.
module rom_responder #(
   parameter int BYTES   = 8,   // at least 2
   parameter int TIMEOUT = 255  // 0 disables the read timeout
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 empty,
   output logic                 rd_en,
   input  logic [7:0]           dout,
   input  logic                 full,
   output logic                 wr_en,
   output logic [7:0]           din,
   output logic                 mem_req,
   output logic [8*BYTES-1:0]   mem_addr,
   input  logic                 mem_ack,
   input  logic [8*BYTES-1:0]   mem_rdata,
   output logic                 busy,
   output logic [7:0]           err_cnt
);
   localparam int W  = 8*BYTES;
   localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BYTES-1);
   localparam logic [TW-1:0] TMR_LAST = TW'((TIMEOUT > 0) ? TIMEOUT-1 : 0);

   typedef enum logic [1:0] {CMD_RD, CMD_CAP, MEM, RSP} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [W-1:0]  r_addr;
   logic [W-1:0]  r_data;
   logic [CW-1:0] r_cnt;
   logic [TW-1:0] r_timer;
   logic [7:0]    r_err_cnt;
   logic          w_cnt_last;
   logic          w_timeout;

   assign w_cnt_last = (r_cnt == CNT_LAST);
   assign w_timeout  = (TIMEOUT != 0) && (r_timer == TMR_LAST) && !mem_ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= CMD_RD;
      else     r_state <= w_next;
   end

   // rd_en is gated by rst so the pop strobe is quiet while reset is held, even with data waiting
   always_comb begin
      w_next  = r_state;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      mem_req = 1'b0;
      case (r_state)
         CMD_RD: begin
            rd_en = !empty && !rst;
            if (!empty) w_next = CMD_CAP;
         end
         CMD_CAP: w_next = w_cnt_last ? MEM : CMD_RD;
         MEM: begin
            mem_req = 1'b1;
            if (mem_ack || w_timeout) w_next = RSP;
         end
         RSP: begin
            wr_en = !full;
            if (!full && w_cnt_last) w_next = CMD_RD;
         end
         default: w_next = CMD_RD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr    <= '0;
         r_data    <= '0;
         r_cnt     <= '0;
         r_timer   <= '0;
         r_err_cnt <= '0;
      end else begin
         case (r_state)
            CMD_CAP: begin
               r_addr <= {dout, r_addr[W-1:8]};
               r_cnt  <= w_cnt_last ? '0 : r_cnt + CW'(1);
            end
            MEM: begin
               if (mem_ack) begin
                  r_data  <= mem_rdata;
                  r_timer <= '0;
               end else if (w_timeout) begin
                  r_data  <= '1;
                  r_timer <= '0;
                  if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            RSP: begin
               if (!full) begin
                  r_data <= {8'h00, r_data[W-1:8]};
                  r_cnt  <= w_cnt_last ? '0 : r_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign din      = r_data[7:0];
   assign mem_addr = r_addr;
   assign busy     = (r_state != CMD_RD) || (r_cnt != '0);
   assign err_cnt  = r_err_cnt;
endmodule
